// File: rtl/process_scheduler.sv
// process_scheduler: deterministic round-robin step sequencer.
// A run is one INIT cycle, then per step one grant per eligible process in
// ascending index order, then a CHECK cycle at the step boundary. The run
// ends when every process has stopped or when the step budget is used up.
// Optional feature macro: SCHEDULER_SKIP_STOPPED_EN. When it is defined,
// processes whose stop flag is set receive no grant.
module process_scheduler #(
  parameter int PROCESSES  = 4,
  parameter int STEP_WIDTH = 16,
  localparam int IDX_WIDTH = (PROCESSES > 1) ? $clog2(PROCESSES) : 1
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  start,
  input  logic                  abort,
  input  logic [STEP_WIDTH-1:0] maxSteps,
  input  logic [PROCESSES-1:0]  processStop,
  output logic                  init,
  output logic [PROCESSES-1:0]  processEnable,
  output logic [IDX_WIDTH-1:0]  processCurrent,
  output logic                  stepDone,
  output logic [STEP_WIDTH-1:0] step,
  output logic                  running,
  output logic                  done,
  output logic                  timeout
);

  typedef enum logic [2:0] {IDLE, INIT, RUN, CHECK, DONE} state_t;

  // Largest budget accepted; anything with the top bit set saturates here so
  // the signed step number never wraps negative before the run ends.
  localparam logic [STEP_WIDTH-1:0] STEP_MAX = {1'b0, {(STEP_WIDTH-1){1'b1}}};

  state_t                state_reg, state_next;
  logic [STEP_WIDTH-1:0] max_reg, max_next;
  logic [STEP_WIDTH-1:0] step_reg, step_next;
  logic [STEP_WIDTH-1:0] step_inc;
  logic [IDX_WIDTH-1:0]  cur_reg, cur_next;
  logic [PROCESSES-1:0]  en_reg, en_next;
  logic                  timeout_reg, timeout_next;
  logic                  init_reg, step_done_reg, running_reg, done_reg;

  logic [PROCESSES-1:0]  eligible;
  logic                  first_found, later_found;
  logic [IDX_WIDTH-1:0]  first_idx, later_idx;
  logic                  all_stopped;

  // Per-process eligibility: stopped processes are skipped only when the
  // skip feature is built in; otherwise every process is granted every step.
  generate
    for (genvar gi = 0; gi < PROCESSES; gi++) begin : g_elig
`ifdef SCHEDULER_SKIP_STOPPED_EN
      assign eligible[gi] = ~processStop[gi];
`else
      assign eligible[gi] = 1'b1;
`endif
    end
  endgenerate

  assign all_stopped = &processStop;
  assign step_inc    = step_reg + STEP_WIDTH'(1);

  // Priority search: lowest eligible index overall, and lowest eligible
  // index above the process currently granted.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    later_found = 1'b0;
    later_idx   = '0;
    for (int i = PROCESSES - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        first_found = 1'b1;
        first_idx   = IDX_WIDTH'(i);
      end
      if (eligible[i] && (i > int'(cur_reg))) begin
        later_found = 1'b1;
        later_idx   = IDX_WIDTH'(i);
      end
    end
  end

  // Next-state and next-output logic; every output is then registered.
  always_comb begin
    state_next   = state_reg;
    max_next     = max_reg;
    step_next    = step_reg;
    cur_next     = '0;
    en_next      = '0;
    timeout_next = timeout_reg;

    unique case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next   = INIT;
          max_next     = maxSteps[STEP_WIDTH-1] ? STEP_MAX : maxSteps;
          timeout_next = 1'b0;
          step_next    = '1;
        end
      end
      INIT: begin
        step_next = '0;
        if (max_reg == '0) begin
          state_next   = DONE;
          timeout_next = ~all_stopped;
        end else if (first_found) begin
          state_next = RUN;
          cur_next   = first_idx;
          en_next    = PROCESSES'(1) << first_idx;
        end else begin
          state_next = CHECK;
        end
      end
      RUN: begin
        if (later_found) begin
          cur_next = later_idx;
          en_next  = PROCESSES'(1) << later_idx;
        end else begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        step_next = step_inc;
        if (all_stopped) begin
          state_next   = DONE;
          timeout_next = 1'b0;
        end else if (step_inc >= max_reg) begin
          state_next   = DONE;
          timeout_next = 1'b1;
        end else if (first_found) begin
          state_next = RUN;
          cur_next   = first_idx;
          en_next    = PROCESSES'(1) << first_idx;
        end else begin
          state_next = CHECK;
        end
      end
      default: state_next = IDLE;
    endcase

    // Abort overrides everything and restores the idle output values.
    if (abort) begin
      state_next   = IDLE;
      max_next     = '0;
      step_next    = '0;
      cur_next     = '0;
      en_next      = '0;
      timeout_next = 1'b0;
    end
  end

  // State and registered outputs; reset clears them immediately.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_reg     <= IDLE;
      max_reg       <= '0;
      step_reg      <= '0;
      cur_reg       <= '0;
      en_reg        <= '0;
      timeout_reg   <= 1'b0;
      init_reg      <= 1'b0;
      step_done_reg <= 1'b0;
      running_reg   <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      max_reg       <= max_next;
      step_reg      <= step_next;
      cur_reg       <= cur_next;
      en_reg        <= en_next;
      timeout_reg   <= timeout_next;
      init_reg      <= (state_next == INIT);
      step_done_reg <= (state_next == CHECK);
      running_reg   <= (state_next == INIT) || (state_next == RUN) || (state_next == CHECK);
      done_reg      <= (state_next == DONE);
    end
  end

  assign init           = init_reg;
  assign processEnable  = en_reg;
  assign processCurrent = cur_reg;
  assign stepDone       = step_done_reg;
  assign step           = step_reg;
  assign running        = running_reg;
  assign done           = done_reg;
  assign timeout        = timeout_reg;

endmodule

// File: tb/tb_process_scheduler.sv
// Directed testbench for process_scheduler with two processes.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_process_scheduler;

  logic        clock;
  logic        resetN;
  logic        start;
  logic        abort;
  logic [15:0] maxSteps;
  logic [1:0]  processStop;
  logic        init;
  logic [1:0]  processEnable;
  logic [0:0]  processCurrent;
  logic        stepDone;
  logic [15:0] step;
  logic        running;
  logic        done;
  logic        timeout;

  int pass_count  = 0;
  int check_count = 0;

  process_scheduler #(.PROCESSES(2), .STEP_WIDTH(16)) dut (
    .clock          (clock),
    .resetN         (resetN),
    .start          (start),
    .abort          (abort),
    .maxSteps       (maxSteps),
    .processStop    (processStop),
    .init           (init),
    .processEnable  (processEnable),
    .processCurrent (processCurrent),
    .stepDone       (stepDone),
    .step           (step),
    .running        (running),
    .done           (done),
    .timeout        (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observed output bundle: init, enable, current, stepDone, running, done, timeout, step.
  logic [23:0] obs;
  assign obs = {init, processEnable, processCurrent, stepDone, running, done, timeout, step};

  function automatic logic [23:0] ev(input logic i, input logic [1:0] en, input logic c,
                                     input logic sd, input logic r, input logic d,
                                     input logic t, input logic [15:0] s);
    return {i, en, c, sd, r, d, t, s};
  endfunction

  localparam logic [23:0] IDLE_V = 24'h0;

  task automatic go_idle;
    @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
  endtask

  // Pulse start for one cycle; returns with INIT visible on the outputs.
  task automatic launch(input logic [15:0] ms, input logic [1:0] ps);
    @(negedge clock);
    maxSteps    = ms;
    processStop = ps;
    start       = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic test_reset;
    if (obs !== IDLE_V) $display("FAIL reset: got %h expected %h", obs, IDLE_V);
    else pass_count++;
    check_count++;
  endtask

  task automatic test_budget;
    logic [23:0] q[$];
    q.push_back(ev(1, 2'b00, 0, 0, 1, 0, 0, 16'hFFFF));
    for (int s = 0; s < 3; s++) begin
      q.push_back(ev(0, 2'b01, 0, 0, 1, 0, 0, 16'(s)));
      q.push_back(ev(0, 2'b10, 1, 0, 1, 0, 0, 16'(s)));
      q.push_back(ev(0, 2'b00, 0, 1, 1, 0, 0, 16'(s)));
    end
    q.push_back(ev(0, 2'b00, 0, 0, 0, 1, 1, 16'd3));
    q.push_back(ev(0, 2'b00, 0, 0, 0, 1, 1, 16'd3));
    go_idle();
    launch(16'd3, 2'b00);
    foreach (q[i]) begin
      if (obs !== q[i]) $display("FAIL budget[%0d]: got %h expected %h", i, obs, q[i]);
      else pass_count++;
      check_count++;
      @(negedge clock);
    end
  endtask

  task automatic test_all_stop;
    logic [23:0] q[$];
    q.push_back(ev(1, 2'b00, 0, 0, 1, 0, 0, 16'hFFFF));
    q.push_back(ev(0, 2'b01, 0, 0, 1, 0, 0, 16'd0));
    q.push_back(ev(0, 2'b10, 1, 0, 1, 0, 0, 16'd0));
    q.push_back(ev(0, 2'b00, 0, 1, 1, 0, 0, 16'd0));
    q.push_back(ev(0, 2'b01, 0, 0, 1, 0, 0, 16'd1));
    q.push_back(ev(0, 2'b10, 1, 0, 1, 0, 0, 16'd1));
    q.push_back(ev(0, 2'b00, 0, 1, 1, 0, 0, 16'd1));
    q.push_back(ev(0, 2'b00, 0, 0, 0, 1, 0, 16'd2));
    q.push_back(ev(0, 2'b00, 0, 0, 0, 1, 0, 16'd2));
    go_idle();
    launch(16'd100, 2'b00);
    foreach (q[i]) begin
      if (obs !== q[i]) $display("FAIL all_stop[%0d]: got %h expected %h", i, obs, q[i]);
      else pass_count++;
      check_count++;
      if (i == 5) processStop = 2'b11;
      @(negedge clock);
    end
    processStop = 2'b00;
  endtask

  task automatic test_skip;
    logic [23:0] q[$];
    q.push_back(ev(1, 2'b00, 0, 0, 1, 0, 0, 16'hFFFF));
    for (int s = 0; s < 2; s++) begin
`ifndef SCHEDULER_SKIP_STOPPED_EN
      q.push_back(ev(0, 2'b01, 0, 0, 1, 0, 0, 16'(s)));
`endif
      q.push_back(ev(0, 2'b10, 1, 0, 1, 0, 0, 16'(s)));
      q.push_back(ev(0, 2'b00, 0, 1, 1, 0, 0, 16'(s)));
    end
    q.push_back(ev(0, 2'b00, 0, 0, 0, 1, 1, 16'd2));
    go_idle();
    launch(16'd2, 2'b01);
    foreach (q[i]) begin
      if (obs !== q[i]) $display("FAIL skip[%0d]: got %h expected %h", i, obs, q[i]);
      else pass_count++;
      check_count++;
      @(negedge clock);
    end
    processStop = 2'b00;
  endtask

  task automatic test_zero_budget;
    logic [23:0] q[$];
    q.push_back(ev(1, 2'b00, 0, 0, 1, 0, 0, 16'hFFFF));
    q.push_back(ev(0, 2'b00, 0, 0, 0, 1, 1, 16'd0));
    q.push_back(ev(0, 2'b00, 0, 0, 0, 1, 1, 16'd0));
    go_idle();
    launch(16'd0, 2'b00);
    foreach (q[i]) begin
      if (obs !== q[i]) $display("FAIL zero_budget[%0d]: got %h expected %h", i, obs, q[i]);
      else pass_count++;
      check_count++;
      @(negedge clock);
    end
  endtask

  task automatic test_async_reset;
    logic [23:0] want;
    go_idle();
    launch(16'd100, 2'b00);
    @(negedge clock);
    want = ev(0, 2'b01, 0, 0, 1, 0, 0, 16'd0);
    if (obs !== want) $display("FAIL reset_pre: got %h expected %h", obs, want);
    else pass_count++;
    check_count++;
    #2 resetN = 1'b0;
    #1;
    if (obs !== IDLE_V) $display("FAIL reset_mid_run: got %h expected %h", obs, IDLE_V);
    else pass_count++;
    check_count++;
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    if (obs !== IDLE_V) $display("FAIL reset_release: got %h expected %h", obs, IDLE_V);
    else pass_count++;
    check_count++;
  endtask

  task automatic test_abort;
    logic [23:0] want;
    go_idle();
    launch(16'd100, 2'b00);
    repeat (3) @(negedge clock);
    want = ev(0, 2'b00, 0, 1, 1, 0, 0, 16'd0);
    if (obs !== want) $display("FAIL abort_pre: got %h expected %h", obs, want);
    else pass_count++;
    check_count++;
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    if (obs !== IDLE_V) $display("FAIL abort_check: got %h expected %h", obs, IDLE_V);
    else pass_count++;
    check_count++;
    @(negedge clock);
    if (obs !== IDLE_V) $display("FAIL abort_hold: got %h expected %h", obs, IDLE_V);
    else pass_count++;
    check_count++;
  endtask

  task automatic test_back_to_back;
    logic [23:0] q[$];
    q.push_back(ev(1, 2'b00, 0, 0, 1, 0, 0, 16'hFFFF));
    for (int s = 0; s < 2; s++) begin
      q.push_back(ev(0, 2'b01, 0, 0, 1, 0, 0, 16'(s)));
      q.push_back(ev(0, 2'b10, 1, 0, 1, 0, 0, 16'(s)));
      q.push_back(ev(0, 2'b00, 0, 1, 1, 0, 0, 16'(s)));
    end
    q.push_back(ev(0, 2'b00, 0, 0, 0, 1, 1, 16'd2));
    // Restart from DONE with a one-step budget; timeout must clear in INIT.
    q.push_back(ev(1, 2'b00, 0, 0, 1, 0, 0, 16'hFFFF));
    q.push_back(ev(0, 2'b01, 0, 0, 1, 0, 0, 16'd0));
    q.push_back(ev(0, 2'b10, 1, 0, 1, 0, 0, 16'd0));
    q.push_back(ev(0, 2'b00, 0, 1, 1, 0, 0, 16'd0));
    q.push_back(ev(0, 2'b00, 0, 0, 0, 1, 1, 16'd1));
    go_idle();
    launch(16'd2, 2'b00);
    foreach (q[i]) begin
      if (obs !== q[i]) $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs, q[i]);
      else pass_count++;
      check_count++;
      start = (i == 1) || (i == 7);
      maxSteps = (i == 1) ? 16'd7 : 16'd1;
      @(negedge clock);
    end
    start = 1'b0;
  endtask

  initial begin
    resetN      = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    maxSteps    = 16'd0;
    processStop = 2'b00;
    @(negedge clock);
    test_reset();
    resetN = 1'b1;
    test_budget();
    test_all_stop();
    test_skip();
    test_zero_budget();
    test_async_reset();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
